// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the configurable UART receive channel.
//   - rx_state_e     : receiver FSM state encoding
//   - PAR_*          : parity mode codes as seen on i_Parity_Mode
//   - BPC_*          : bits-per-character codes as seen on i_Bits_Per_Char
//   - ST_*           : bit positions of the flags inside the 3-bit status field
//   - DATA_W/ENTRY_W : layout of one FIFO entry {brk, fe, pe, data[7:0]}
//   - char_bits()    : decode a BPC code to a data bit count
//   - parity_enabled(): true for the even/odd parity codes
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] BPC_5 = 2'b00;
  localparam logic [1:0] BPC_6 = 2'b01;
  localparam logic [1:0] BPC_7 = 2'b10;
  localparam logic [1:0] BPC_8 = 2'b11;

  localparam int ST_BRK = 2;
  localparam int ST_FE  = 1;
  localparam int ST_PE  = 0;

  localparam int DATA_W   = 8;
  localparam int STATUS_W = 3;
  localparam int ENTRY_W  = 11;

  function automatic logic [3:0] char_bits(input logic [1:0] code);
    logic [3:0] n;
    case (code)
      BPC_5:   n = 4'd5;
      BPC_6:   n = 4'd6;
      BPC_7:   n = 4'd7;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

  // 2'b11 is an alias for "no parity", so only the two real codes count.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_channel_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_sync_fifo
// Generic synchronous first-word-fall-through FIFO. The head entry is visible
// on o_dout whenever the FIFO is non-empty and reads as zero when empty.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push, i_din: write request and data
//   i_pop        : remove the head entry (ignored when empty)
//   o_dout       : head entry (0 when empty)
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
// A push while full is dropped unless a pop happens in the same cycle, in
// which case both take effect.
// ---------------------------------------------------------------------------
module uart_rx_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept
  // a push when it is paired with a pop.
  always_comb begin
    do_pop   = i_pop && !o_empty;
    do_push  = i_push && (!o_full || do_pop);
    wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_din;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fifo_channel.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_channel
// Configurable UART receive channel: runtime baud divisor with 16x
// oversampling and 3-sample majority vote, 5-8 data bits, optional even/odd
// parity, framing/parity/break/overrun detection and a FWFT receive FIFO.
// Ports:
//   i_Clock, i_Rst    : clock, synchronous active-high reset
//   i_Baud_Div        : clocks per oversample tick minus 1
//   i_RX_Enable       : receiver enable (0 aborts any character in flight)
//   i_Bits_Per_Char   : 00=5, 01=6, 10=7, 11=8 data bits
//   i_Parity_Mode     : 00=none, 01=even, 10=odd, 11=none
//   i_RX_Serial       : asynchronous serial line, idle high
//   i_Rd              : pop the FIFO head
//   i_Clr_Err         : clear the sticky overrun flag
//   o_RX_Byte         : head data, unused upper bits 0
//   o_RX_Status       : head flags {break, framing, parity}
//   o_RX_Ready        : FIFO not empty
//   o_FIFO_Full       : FIFO full
//   o_Overrun         : sticky overrun flag
// ---------------------------------------------------------------------------
module uart_rx_fifo_channel
  import uart_rx_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 3,
  parameter int OVERSAMPLE = 16
) (
  input  logic                i_Clock,
  input  logic                i_Rst,
  input  logic [DIV_W-1:0]    i_Baud_Div,
  input  logic                i_RX_Enable,
  input  logic [1:0]          i_Bits_Per_Char,
  input  logic [1:0]          i_Parity_Mode,
  input  logic                i_RX_Serial,
  input  logic                i_Rd,
  input  logic                i_Clr_Err,
  output logic [DATA_W-1:0]   o_RX_Byte,
  output logic [STATUS_W-1:0] o_RX_Status,
  output logic                o_RX_Ready,
  output logic                o_FIFO_Full,
  output logic                o_Overrun
);

  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam logic [SAMP_W-1:0] SAMP_EARLY  = SAMP_W'(MID - 1);
  localparam logic [SAMP_W-1:0] SAMP_MID    = SAMP_W'(MID);
  localparam logic [SAMP_W-1:0] SAMP_DECIDE = SAMP_W'(MID + 1);

  logic                rx_meta_q, rx_sync_q;
  rx_state_e           state_q, state_d;
  logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [3:0]          nbits_q, nbits_d;
  logic [1:0]          par_mode_q, par_mode_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                samp_early_q, samp_early_d;
  logic                samp_mid_q, samp_mid_d;
  logic                pe_q, pe_d;
  logic                par_bit_q, par_bit_d;
  logic                push_q, push_d;
  logic [ENTRY_W-1:0]  entry_q, entry_d;
  logic                overrun_q, overrun_d;

  logic                tick, decide, maj, fe, brk;
  logic [ENTRY_W-1:0]  fifo_head;
  logic                fifo_full, fifo_empty;

  // Tick counter is parked at 0 in IDLE so the first tick after a start edge
  // lands at a fixed offset from that edge.
  always_comb begin
    tick       = (state_q != S_IDLE) && (tick_cnt_q == i_Baud_Div);
    tick_cnt_d = (state_q == S_IDLE || tick) ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d = (state_q == S_IDLE) ? '0 : (tick ? samp_cnt_q + 1'b1 : samp_cnt_q);
    decide     = tick && (samp_cnt_q == SAMP_DECIDE);
    samp_early_d = (tick && samp_cnt_q == SAMP_EARLY) ? rx_sync_q : samp_early_q;
    samp_mid_d   = (tick && samp_cnt_q == SAMP_MID)   ? rx_sync_q : samp_mid_q;
    // The third sample is the live line value at the decision tick.
    maj = (samp_early_q & samp_mid_q) | (samp_early_q & rx_sync_q) |
          (samp_mid_q & rx_sync_q);
  end

  // Every state makes its decision at the same tick of its bit; the sample
  // counter keeps running to the end of the bit regardless of state.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    nbits_d    = nbits_q;
    par_mode_d = par_mode_q;
    data_d     = data_q;
    pe_d       = pe_q;
    par_bit_d  = par_bit_q;
    entry_d    = entry_q;
    push_d     = 1'b0;
    fe         = 1'b0;
    brk        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_sync_q && i_RX_Enable) begin
          state_d    = S_START;
          nbits_d    = char_bits(i_Bits_Per_Char);
          par_mode_d = i_Parity_Mode;
          data_d     = '0;
          pe_d       = 1'b0;
          par_bit_d  = 1'b0;
          bit_idx_d  = '0;
        end
      end
      S_START: begin
        if (decide) begin
          state_d   = maj ? S_IDLE : S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (decide) begin
          data_d[bit_idx_q] = maj;
          if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
            state_d = parity_enabled(par_mode_q) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (decide) begin
          par_bit_d = maj;
          // Unreceived upper data bits are 0, so they do not disturb the XOR.
          if (par_mode_q == PAR_EVEN) begin
            pe_d = (^data_q) ^ maj;
          end else begin
            pe_d = ~((^data_q) ^ maj);
          end
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (decide) begin
          fe  = ~maj;
          brk = fe && (data_q == '0) && !(parity_enabled(par_mode_q) && par_bit_q);
          entry_d                  = '0;
          entry_d[DATA_W-1:0]      = data_q;
          entry_d[DATA_W + ST_BRK] = brk;
          entry_d[DATA_W + ST_FE]  = fe;
          entry_d[DATA_W + ST_PE]  = pe_q;
          push_d  = 1'b1;
          state_d = maj ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Dropping the enable abandons whatever character is in flight.
    if (!i_RX_Enable) begin
      state_d = S_IDLE;
      push_d  = 1'b0;
    end
  end

  // A push that finds the FIFO full and unpaired with a read is lost; the
  // set condition takes priority over a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (i_Clr_Err) begin
      overrun_d = 1'b0;
    end
    if (push_q && fifo_full && !i_Rd) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      samp_cnt_q   <= '0;
      bit_idx_q    <= '0;
      nbits_q      <= 4'd8;
      par_mode_q   <= PAR_NONE;
      data_q       <= '0;
      samp_early_q <= 1'b1;
      samp_mid_q   <= 1'b1;
      pe_q         <= 1'b0;
      par_bit_q    <= 1'b0;
      push_q       <= 1'b0;
      entry_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= i_RX_Serial;
      rx_sync_q    <= rx_meta_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      bit_idx_q    <= bit_idx_d;
      nbits_q      <= nbits_d;
      par_mode_q   <= par_mode_d;
      data_q       <= data_d;
      samp_early_q <= samp_early_d;
      samp_mid_q   <= samp_mid_d;
      pe_q         <= pe_d;
      par_bit_q    <= par_bit_d;
      push_q       <= push_d;
      entry_q      <= entry_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_Clock),
    .i_rst   (i_Rst),
    .i_push  (push_q),
    .i_din   (entry_q),
    .i_pop   (i_Rd),
    .o_dout  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_RX_Byte   = fifo_head[DATA_W-1:0];
  assign o_RX_Status = fifo_head[ENTRY_W-1:DATA_W];
  assign o_RX_Ready  = !fifo_empty;
  assign o_FIFO_Full = fifo_full;
  assign o_Overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo_channel.md
Name: uart_rx_fifo_channel

Overview:
Next-generation UART receive channel for the MC68681-compatible DUART core. It replaces the fixed 8N1, fixed-divisor receiver with a configurable one:
- runtime baud divisor with 16x oversampling and 3-sample majority vote;
- 5-8 data bits, optional even/odd parity;
- framing, parity, break and overrun detection;
- a small first-word-fall-through receive FIFO read by the host bus interface.

Parameters:
DIV_W, 16, width of the baud divisor input
FIFO_DEPTH, 3, receive holding FIFO entries (68681 holds 3); legal range 2-8
OVERSAMPLE, 16, ticks per bit; fixed at 16, with mid-bit at tick 8

Ports:
i_Clock  in  1  system clock
i_Rst  in  1  synchronous reset, active-high
i_Baud_Div  in  DIV_W  clocks per oversample tick minus 1 (0 = tick every clock)
i_RX_Enable  in  1  receiver enable
i_Bits_Per_Char  in  2  00=5, 01=6, 10=7, 11=8 data bits
i_Parity_Mode  in  2  00=none, 01=even, 10=odd, 11=none
i_RX_Serial  in  1  asynchronous serial line, idle high
i_Rd  in  1  pop FIFO head (one-cycle pulse)
i_Clr_Err  in  1  clear sticky overrun
o_RX_Byte  out  8  FIFO head data; unused upper bits 0
o_RX_Status  out  3  FIFO head flags {break, framing, parity}
o_RX_Ready  out  1  FIFO not empty
o_FIFO_Full  out  1  FIFO full
o_Overrun  out  1  sticky overrun flag

Behaviour:
- Reset: all state is cleared.
  - FSM goes to IDLE; tick counter, sample counters and FIFO pointers/count are 0.
  - o_RX_Byte=0, o_RX_Status=0, o_RX_Ready=0, o_FIFO_Full=0, o_Overrun=0.
  - Reset mid-character discards the character.
- Input synchroniser: i_RX_Serial passes through a 2-flop synchroniser, reset value 1. All detection uses the synchronised value.
- Tick generator: counter runs 0..i_Baud_Div and pulses tick on the terminal count, then wraps to 0. It free-runs except in IDLE, where it is held at 0 so start detection is phase-aligned.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - If synced line=0 and i_RX_Enable=1, go to START.
  - On that same entry, latch i_Bits_Per_Char and i_Parity_Mode. A config change mid-character has no effect until the next start.
- Sampling: a bit value is the majority of the samples at ticks 7, 8 and 9 within the bit. The decision is made at tick 9, then the bit counter continues to 15.
- START: at the decision point, majority=1 is a glitch → IDLE, no entry. Majority=0 → DATA with bit index 0.
- DATA:
  - Data is LSB-first, 16 ticks per bit.
  - After bit N-1 (N = latched width), go to PARITY if parity is enabled, else STOP.
- PARITY:
  - Even mode: pe = XOR(data bits, parity bit) != 0.
  - Odd mode: pe = XOR(data bits, parity bit) == 0.
- STOP:
  - Only one stop bit is checked. fe = (stop sample == 0).
  - brk = fe AND all data bits 0 AND parity bit 0 (when enabled).
  - The entry {brk, fe, pe, data} is pushed on the cycle after the stop decision point. The FSM does not wait for end of the stop bit.
  - If stop=1 → IDLE; if stop=0 → WAIT_HIGH.
- WAIT_HIGH: stay until synced line=1, then go to IDLE. A held break therefore produces exactly one entry.
- FIFO (first-word fall-through):
  - o_RX_Byte and o_RX_Status reflect the head combinationally from storage; they read 0 when empty.
  - o_RX_Ready asserts the cycle after the push. Latency from the stop decision point to o_RX_Ready=1 is 2 clocks.
- FIFO boundary conditions:
  - i_Rd while empty: ignored.
  - Push while full without i_Rd: new character discarded, FIFO unchanged, o_Overrun set (sticky).
  - Push and i_Rd in the same cycle while full: pop and push both occur, no overrun.
  - Push and i_Rd in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
- Overrun control:
  - i_Clr_Err clears o_Overrun.
  - If i_Clr_Err and a new overrun occur in the same cycle, set wins.
- Enable: i_RX_Enable=0 forces the FSM to IDLE on the next clock and discards any in-progress character. FIFO contents and o_Overrun are retained.

Decomposition:
- Package uart_rx_pkg holds:
  - FSM state encoding;
  - parity mode codes (PAR_NONE, PAR_EVEN, PAR_ODD);
  - bits-per-char codes;
  - status bit indices (ST_BRK=2, ST_FE=1, ST_PE=0);
  - entry width constant ENTRY_W=11.
- One sub-module: uart_rx_sync_fifo, a generic synchronous FWFT FIFO (width, depth) with push/pop/full/empty and simultaneous push+pop when full.

Test Plan:
All tests use i_Baud_Div=3 (64 clocks per bit) unless stated.
1. 8N1, send 0xA5 → single entry: o_RX_Byte=0xA5, o_RX_Status=000, o_RX_Ready rises 2 clocks after the stop-bit decision point; i_Rd → o_RX_Ready=0.
2. 7E1, send 0x41 with parity bit 1 (wrong) → byte 0x41, status=001. Repeat with parity 0 → status=000. 8O1 with 0x00 and parity 1 → status=000.
3. 5N1, send 0x15 followed by high line → o_RX_Byte=0x15 with upper bits 0. Then switch i_Bits_Per_Char mid-character → current character is still decoded as 5 bits.
4. 8N1, 0x3C with stop=0 → status=010, then the line goes high. Separately, hold the line low for 12 bit times → exactly one entry 0x00, status=110, and no further entries until the line returns high.
5. Send 4 characters 0x01..0x04 with no reads (depth 3) → head sequence 0x01, 0x02, 0x03, o_FIFO_Full=1, o_Overrun=1, 0x04 lost. i_Clr_Err → o_Overrun=0. Also push coincident with i_Rd when full → no overrun.
6. Glitch: line low for 4 ticks only → no entry, FSM back to IDLE. Assert i_Rst or drop i_RX_Enable mid-DATA → no entry; with i_RX_Enable, prior FIFO contents are kept; a following clean 0x5A is received correctly.
